// File: rtl/fifo_pkg.sv
// Shared FIFO constants, arbiter state encoding and elaboration-time helpers.
package fifo_pkg;

  localparam int unsigned FIFO_DW    = 32;
  localparam int unsigned FIFO_DEPTH = 512;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod NREQ.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any_req,
  output logic [IDW-1:0]  idx
);

  logic [NREQ-1:0] rot;
  logic [IDW-1:0]  rot_idx;

  // Explicit wrap so non-power-of-two NREQ never indexes past the vector.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rot[i] = req[wrap_add(ptr, i)];
    end
  end

  always_comb begin
    rot_idx = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (rot[i]) rot_idx = IDW'(i);
    end
  end

  assign any_req = |req;
  assign idx     = wrap_add(ptr, 32'(rot_idx));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers,
// with grants capped at BURST words.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = FIFO_DW,
  parameter int unsigned BURST = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [DW-1:0]      fifo_wr_data,
  output logic               grant_valid,
  output logic [IDW-1:0]     grant_id,
  output logic [15:0]        xfer_cnt
);

  localparam int unsigned    BCW       = clog2(BURST) + 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST - 1);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] pick_idx;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]    xfer_cnt_q, xfer_cnt_d;
  logic [DW-1:0]  wr_data_q, wr_data_d;
  logic [DW-1:0]  owner_data;
  logic           any_req;
  logic           owner_valid;
  logic           xfer;

  rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_rr_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .any_req(any_req),
    .idx    (pick_idx)
  );

  assign owner_valid = req_valid[owner_q];
  assign owner_data  = req_data[32'(owner_q) * DW +: DW];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    xfer_cnt_d = xfer_cnt_q;
    wr_data_d  = wr_data_q;
    req_ready  = '0;
    xfer       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        req_ready[owner_q] = ~fifo_full;
        xfer               = owner_valid & ~fifo_full;
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + BCW'(1);
          xfer_cnt_d = xfer_cnt_q + 16'd1;
          wr_data_d  = owner_data;
        end
        if ((xfer && (beat_cnt_q == LAST_BEAT)) || !owner_valid) begin
          rr_ptr_d = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A burst interrupted by reset must not leak a write or a handshake.
    if (reset) begin
      req_ready = '0;
      xfer      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      xfer_cnt_q <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      xfer_cnt_q <= xfer_cnt_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign fifo_wr_en   = xfer;
  assign fifo_wr_data = xfer ? owner_data : wr_data_q;
  assign grant_valid  = (state_q == ST_GRANT);
  assign grant_id     = owner_q;
  assign xfer_cnt     = xfer_cnt_q;

endmodule
